// File: rtl/prbs_test_ctrl.sv
// ---------------------------------------------------------------------------
// prbs_test_ctrl
//
// Sequencer for a PRBS link test. It holds the pattern generator in reset
// for a fixed number of cycles and releases it. It then measures the
// round-trip latency from the generator's start marker to the far-end
// checker's start detect. While the test runs it counts cycles and word
// errors, and it finishes on a programmed length, an abort, or a latency
// timeout.
//
// Parameters
//   HOLD_CYC  cycles PRBS_RST is held high after START (1..255)
//   LAT_MAX   latency / alignment timeout in GEN_CLK cycles (1..255)
//
// Optional feature
//   PRBS_INJ_EN  when defined, INJ_REQ sampled in RUN produces a one-cycle
//                INJ_ERR strobe on the following cycle. When undefined,
//                INJ_ERR is tied low and INJ_REQ is ignored.
//
// Ports
//   GEN_CLK   in   1   sole clock, rising edge
//   RST       in   1   synchronous active-high reset
//   START     in   1   test start request (IDLE/END/TOUT only)
//   STOP      in   1   abort/end request
//   RUN_LEN   in  32   test length in RUN cycles, 0 = until STOP
//   INJ_REQ   in   1   request to corrupt one generator word
//   TX_STRT   in   1   start-pattern marker from the generator
//   RX_STRT   in   1   start-pattern detect from the checker
//   RX_ERR    in   1   per-cycle word-mismatch flag from the checker
//   PRBS_RST  out  1   generator reset
//   INJ_ERR   out  1   error-inject strobe to the generator
//   BUSY      out  1   test in progress (HOLD/ALIGN/RUN)
//   DONE      out  1   test ended normally (END)
//   FAIL      out  1   latency timeout (TOUT)
//   LATENCY   out  8   measured start-marker latency
//   ERR_CNT   out 32   errored RUN cycles, saturating
//   CYC_CNT   out 32   RUN cycles, saturating
//   STATE     out  3   current FSM state
// ---------------------------------------------------------------------------
module prbs_test_ctrl #(
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned LAT_MAX  = 200
) (
  input  logic        GEN_CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic [31:0] RUN_LEN,
  input  logic        INJ_REQ,
  input  logic        TX_STRT,
  input  logic        RX_STRT,
  input  logic        RX_ERR,
  output logic        PRBS_RST,
  output logic        INJ_ERR,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAIL,
  output logic [7:0]  LATENCY,
  output logic [31:0] ERR_CNT,
  output logic [31:0] CYC_CNT,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_RUN   = 3'd3,
    ST_END   = 3'd4,
    ST_TOUT  = 3'd5
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [7:0] LAT_LAST  = 8'(LAT_MAX - 1);
  localparam logic [7:0] LAT_TOP   = 8'(LAT_MAX);

  state_t      state;
  logic [7:0]  hold_cnt;
  logic [7:0]  align_cnt;
  logic [7:0]  lat_cnt;
  logic        tx_seen;
  logic [31:0] run_len_q;

  logic [7:0]  lat_now;
  logic [31:0] cyc_inc;
  logic [31:0] err_inc;

  // The latency counter reads zero on the cycle TX_STRT arrives. This makes
  // a same-cycle TX_STRT/RX_STRT pair report zero latency, and it lets that
  // first cycle take part in the timeout check.
  assign lat_now = tx_seen ? lat_cnt : 8'd0;

  // Both run counters stick at all-ones instead of wrapping.
  assign cyc_inc = (CYC_CNT == 32'hFFFF_FFFF) ? CYC_CNT : CYC_CNT + 32'd1;
  assign err_inc = (ERR_CNT == 32'hFFFF_FFFF) ? ERR_CNT : ERR_CNT + 32'd1;

  assign STATE = state;

  // Main test FSM. Status outputs are registered together with each
  // transition, so they always agree with STATE on the same cycle.
  always_ff @(posedge GEN_CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      PRBS_RST  <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      LATENCY   <= 8'd0;
      ERR_CNT   <= 32'd0;
      CYC_CNT   <= 32'd0;
      hold_cnt  <= 8'd0;
      align_cnt <= 8'd0;
      lat_cnt   <= 8'd0;
      tx_seen   <= 1'b0;
      run_len_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE, ST_END, ST_TOUT: begin
          if (START) begin
            state     <= ST_HOLD;
            PRBS_RST  <= 1'b1;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            LATENCY   <= 8'd0;
            ERR_CNT   <= 32'd0;
            CYC_CNT   <= 32'd0;
            hold_cnt  <= 8'd0;
            run_len_q <= RUN_LEN;
          end
        end

        ST_HOLD: begin
          if (STOP) begin
            state    <= ST_END;
            PRBS_RST <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            LATENCY  <= 8'd0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= ST_ALIGN;
            PRBS_RST  <= 1'b0;
            align_cnt <= 8'd0;
            lat_cnt   <= 8'd0;
            tx_seen   <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        // Once TX_STRT has been seen, RX_STRT captures the latency. If no
        // RX_STRT arrives before the counter would reach LAT_MAX, the test
        // times out. Before TX_STRT, RX_STRT is meaningless, and the
        // separate alignment counter bounds how long we wait for TX_STRT.
        ST_ALIGN: begin
          if (STOP) begin
            state    <= ST_END;
            PRBS_RST <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            LATENCY  <= 8'd0;
          end else if (tx_seen || TX_STRT) begin
            if (RX_STRT) begin
              state   <= ST_RUN;
              LATENCY <= lat_now;
            end else if (lat_now == LAT_LAST) begin
              state    <= ST_TOUT;
              PRBS_RST <= 1'b1;
              BUSY     <= 1'b0;
              FAIL     <= 1'b1;
              LATENCY  <= LAT_TOP;
            end else begin
              tx_seen <= 1'b1;
              lat_cnt <= lat_now + 8'd1;
            end
          end else if (align_cnt == LAT_LAST) begin
            state    <= ST_TOUT;
            PRBS_RST <= 1'b1;
            BUSY     <= 1'b0;
            FAIL     <= 1'b1;
            LATENCY  <= LAT_TOP;
          end else begin
            align_cnt <= align_cnt + 8'd1;
          end
        end

        // The STOP cycle aborts the test and is not counted. The cycle that
        // brings CYC_CNT up to the programmed length is counted and ends
        // the test.
        ST_RUN: begin
          if (STOP) begin
            state    <= ST_END;
            PRBS_RST <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
          end else begin
            CYC_CNT <= cyc_inc;
            if (RX_ERR) begin
              ERR_CNT <= err_inc;
            end
            if ((run_len_q != 32'd0) && (cyc_inc == run_len_q)) begin
              state    <= ST_END;
              PRBS_RST <= 1'b1;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          PRBS_RST <= 1'b1;
          BUSY     <= 1'b0;
          DONE     <= 1'b0;
          FAIL     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PRBS_INJ_EN
  // The inject strobe follows each INJ_REQ sampled in RUN by one cycle.
  // Back-to-back requests therefore give back-to-back strobes, and
  // nothing is queued.
  always_ff @(posedge GEN_CLK) begin
    if (RST) begin
      INJ_ERR <= 1'b0;
    end else begin
      INJ_ERR <= INJ_REQ && (state == ST_RUN);
    end
  end
`else
  logic inj_req_unused;

  assign inj_req_unused = INJ_REQ;
  assign INJ_ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prbs_test_ctrl
//
// Directed bench for prbs_test_ctrl with the default parameters
// (HOLD_CYC=4, LAT_MAX=200). Every expected value is hand-derived from the
// cycle-level behaviour of the controller. Inputs change 1 ns after each
// rising edge, and outputs are checked at the same point. Each
// applyStimulus call therefore shows the result of exactly one clock edge.
// ---------------------------------------------------------------------------
module tb_prbs_test_ctrl;

  localparam logic [31:0] S_IDLE  = 32'd0;
  localparam logic [31:0] S_HOLD  = 32'd1;
  localparam logic [31:0] S_ALIGN = 32'd2;
  localparam logic [31:0] S_RUN   = 32'd3;
  localparam logic [31:0] S_END   = 32'd4;
  localparam logic [31:0] S_TOUT  = 32'd5;

`ifdef PRBS_INJ_EN
  localparam logic [31:0] INJ_ON = 32'd1;
`else
  localparam logic [31:0] INJ_ON = 32'd0;
`endif

  logic        GEN_CLK;
  logic        RST;
  logic        START;
  logic        STOP;
  logic [31:0] RUN_LEN;
  logic        INJ_REQ;
  logic        TX_STRT;
  logic        RX_STRT;
  logic        RX_ERR;
  logic        PRBS_RST;
  logic        INJ_ERR;
  logic        BUSY;
  logic        DONE;
  logic        FAIL;
  logic [7:0]  LATENCY;
  logic [31:0] ERR_CNT;
  logic [31:0] CYC_CNT;
  logic [2:0]  STATE;

  int n_cmp  = 0;
  int n_fail = 0;

  prbs_test_ctrl #(
    .HOLD_CYC (4),
    .LAT_MAX  (200)
  ) dut (
    .GEN_CLK  (GEN_CLK),
    .RST      (RST),
    .START    (START),
    .STOP     (STOP),
    .RUN_LEN  (RUN_LEN),
    .INJ_REQ  (INJ_REQ),
    .TX_STRT  (TX_STRT),
    .RX_STRT  (RX_STRT),
    .RX_ERR   (RX_ERR),
    .PRBS_RST (PRBS_RST),
    .INJ_ERR  (INJ_ERR),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .FAIL     (FAIL),
    .LATENCY  (LATENCY),
    .ERR_CNT  (ERR_CNT),
    .CYC_CNT  (CYC_CNT),
    .STATE    (STATE)
  );

  initial begin
    GEN_CLK = 1'b0;
    forever #5 GEN_CLK = ~GEN_CLK;
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic tx,
                               input logic rx, input logic er, input logic ij);
    START   = st;
    STOP    = sp;
    TX_STRT = tx;
    RX_STRT = rx;
    RX_ERR  = er;
    INJ_REQ = ij;
    @(posedge GEN_CLK);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_state"},   32'(STATE),    S_IDLE);
    checkOutput({pfx, "_prbs"},    32'(PRBS_RST), 32'd1);
    checkOutput({pfx, "_inj"},     32'(INJ_ERR),  32'd0);
    checkOutput({pfx, "_busy"},    32'(BUSY),     32'd0);
    checkOutput({pfx, "_done"},    32'(DONE),     32'd0);
    checkOutput({pfx, "_fail"},    32'(FAIL),     32'd0);
    checkOutput({pfx, "_latency"}, 32'(LATENCY),  32'd0);
    checkOutput({pfx, "_errcnt"},  ERR_CNT,       32'd0);
    checkOutput({pfx, "_cyccnt"},  CYC_CNT,       32'd0);
  endtask

  int hold_hi;
  int n;

  initial begin
    RST     = 1'b1;
    RUN_LEN = 32'd0;
    START = 0; STOP = 0; TX_STRT = 0; RX_STRT = 0; RX_ERR = 0; INJ_REQ = 0;
    @(posedge GEN_CLK);
    #1;
    idleCycles(2);
    checkResetValues("reset");
    RST = 1'b0;

    // An inject request in IDLE must not produce a strobe.
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("inj_idle", 32'(INJ_ERR), 32'd0);
    checkOutput("idle_stays", 32'(STATE), S_IDLE);

    // Test 1: hold length, latency 7, RUN_LEN 1000 with 3 errors in RUN.
    $display("[TB] test 1: hold, latency 7, run length 1000");
    RUN_LEN = 32'd1000;
    hold_hi = 0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("start_hold", 32'(STATE), S_HOLD);
    checkOutput("start_busy", 32'(BUSY), 32'd1);
    if (STATE == 3'd1 && PRBS_RST) hold_hi++;
    RUN_LEN = 32'd5;                          // must not affect this test
    applyStimulus(1, 0, 0, 0, 0, 0);          // START while busy
    checkOutput("start_ignored", 32'(STATE), S_HOLD);
    if (STATE == 3'd1 && PRBS_RST) hold_hi++;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (STATE == 3'd1 && PRBS_RST) hold_hi++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("hold_cycles", 32'(hold_hi), 32'd4);
    checkOutput("align_entered", 32'(STATE), S_ALIGN);
    checkOutput("align_prbs_low", 32'(PRBS_RST), 32'd0);
    applyStimulus(0, 0, 0, 1, 1, 0);          // early RX_STRT + RX_ERR
    checkOutput("early_rx_ignored", 32'(STATE), S_ALIGN);
    applyStimulus(0, 0, 1, 0, 1, 0);          // TX_STRT, RX_ERR again
    idleCycles(6);
    checkOutput("align_wait", 32'(STATE), S_ALIGN);
    applyStimulus(0, 0, 0, 1, 0, 0);          // RX_STRT 7 cycles after TX
    checkOutput("latency_7", 32'(LATENCY), 32'd7);
    checkOutput("run_entered", 32'(STATE), S_RUN);
    checkOutput("align_err_ignored", ERR_CNT, 32'd0);
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(0, 0, 0, 0, (i == 10 || i == 11 || i == 500), 0);
      if (i == 0)   checkOutput("run_busy", 32'(BUSY), 32'd1);
      if (i == 998) checkOutput("run_before_len", 32'(STATE), S_RUN);
    end
    checkOutput("len_end", 32'(STATE), S_END);
    checkOutput("len_done", 32'(DONE), 32'd1);
    checkOutput("len_cyccnt", CYC_CNT, 32'd1000);
    checkOutput("len_errcnt", ERR_CNT, 32'd3);
    checkOutput("len_busy", 32'(BUSY), 32'd0);
    checkOutput("len_prbs", 32'(PRBS_RST), 32'd1);
    applyStimulus(0, 1, 0, 0, 1, 1);          // STOP/RX_ERR/INJ after END
    checkOutput("end_holds", 32'(STATE), S_END);
    checkOutput("end_err_ignored", ERR_CNT, 32'd3);
    checkOutput("end_inj", 32'(INJ_ERR), 32'd0);

    // Test 2: TX_STRT seen but RX_STRT never arrives.
    $display("[TB] test 2: latency timeout");
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("restart_done_clr", 32'(DONE), 32'd0);
    checkOutput("restart_lat_clr", 32'(LATENCY), 32'd0);
    checkOutput("restart_cyc_clr", CYC_CNT, 32'd0);
    checkOutput("restart_err_clr", ERR_CNT, 32'd0);
    idleCycles(4);
    checkOutput("t2_align", 32'(STATE), S_ALIGN);
    applyStimulus(0, 0, 1, 0, 0, 0);
    n = 0;
    while (STATE == 3'd2 && n < 300) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      n++;
    end
    checkOutput("tout_cycles", 32'(n), 32'd199);
    checkOutput("tout_state", 32'(STATE), S_TOUT);
    checkOutput("tout_fail", 32'(FAIL), 32'd1);
    checkOutput("tout_latency", 32'(LATENCY), 32'd200);
    checkOutput("tout_prbs", 32'(PRBS_RST), 32'd1);
    checkOutput("tout_busy", 32'(BUSY), 32'd0);

    // Test 3: TX_STRT never arrives.
    $display("[TB] test 3: alignment timeout");
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t3_fail_clr", 32'(FAIL), 32'd0);
    idleCycles(4);
    n = 0;
    while (STATE == 3'd2 && n < 300) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      n++;
    end
    checkOutput("notx_cycles", 32'(n), 32'd200);
    checkOutput("notx_state", 32'(STATE), S_TOUT);
    checkOutput("notx_latency", 32'(LATENCY), 32'd200);

    // Test 4: zero latency, injection, STOP after 500 RUN cycles.
    $display("[TB] test 4: zero latency, inject, stop at 500");
    RUN_LEN = 32'd0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleCycles(4);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("lat0_state", 32'(STATE), S_RUN);
    checkOutput("lat0_latency", 32'(LATENCY), 32'd0);
    for (int i = 0; i < 500; i++) begin
      applyStimulus(0, 0, 0, 0, 0, (i == 3 || i == 4));
      if (i == 2) checkOutput("inj_before", 32'(INJ_ERR), 32'd0);
      if (i == 3) checkOutput("inj_first", 32'(INJ_ERR), INJ_ON);
      if (i == 4) checkOutput("inj_second", 32'(INJ_ERR), INJ_ON);
      if (i == 5) checkOutput("inj_after", 32'(INJ_ERR), 32'd0);
    end
    checkOutput("run500_state", 32'(STATE), S_RUN);
    checkOutput("run500_cyc", CYC_CNT, 32'd500);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("stop_state", 32'(STATE), S_END);
    checkOutput("stop_cyc", CYC_CNT, 32'd500);
    checkOutput("stop_done", 32'(DONE), 32'd1);

    // Test 5: STOP during HOLD ends the test immediately.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("hold_stop_state", 32'(STATE), S_END);
    checkOutput("hold_stop_done", 32'(DONE), 32'd1);
    checkOutput("hold_stop_lat", 32'(LATENCY), 32'd0);

    // Test 6: reset in the middle of RUN wins over START/STOP/INJ_REQ.
    $display("[TB] test 6: reset mid-run");
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleCycles(4);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mid_cyc", CYC_CNT, 32'd3);
    checkOutput("mid_err", ERR_CNT, 32'd1);
    RST = 1'b1;
    applyStimulus(1, 1, 0, 0, 1, 1);
    checkResetValues("midrst");
    RST = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_idle", 32'(STATE), S_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
